memory_controller: RTL and testbench
====================================

# memory_controller

Single-port memory arbiter and sequencer between the instruction fetcher and the load/store buffer. It owns the byte-wide external RAM/IO port, serialises 1/2/4-byte loads and stores into per-byte accesses, and assembles little-endian results. Load/store traffic has priority over instruction fetch. Flushes abort reads but never committed stores.

## Interface
Parameters:
- ADDR_W, 32, memory address width
- IO_HI, 2'b11, value of addr[17:16] that marks the IO space

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous, active-low reset
- rdy_in  in  1  global ready; low = freeze
- _clear  in  1  pipeline flush (branch mispredict)
- _if_ready  in  1  fetch request, level-held until _if_done
- _if_addr  in  32  fetch byte address (any alignment)
- _if_done  out  1  one-cycle pulse, _if_inst valid
- _if_inst  out  32  fetched word
- _lsb_ready  in  1  load/store request, level-held until _lsb_done
- _lsb_is_store  in  1  1 = store, 0 = load
- _lsb_size  in  2  00 byte, 01 half, 10/11 word
- _lsb_unsigned  in  1  load zero-extends when 1, else sign-extends
- _lsb_addr  in  32  byte address
- _lsb_data  in  32  store data, low bytes used
- _lsb_done  out  1  one-cycle pulse, access finished
- _lsb_result  out  32  extended load data (0 for stores)
- _io_buffer_full  in  1  IO write buffer full
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM address
- mem_wr  out  1  1 = write, 0 = read

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE arbitration each cycle:
  - LSB request accepted first, unless it is a store with addr[17:16]==IO_HI while _io_buffer_full=1. A blocked store is retried every cycle, and IF may be served meanwhile.
  - Otherwise an IF request is accepted.
  - Acceptance latches owner, address, N (IF=4; LSB 1/2/4 from size), store data and signedness. Byte counter is reset to 0.
- READ: drive mem_a = base+k for k=0..N-1, one byte per cycle with mem_wr=0. Byte k is captured from mem_din the cycle after its address, into bits [8k+7:8k]. After the last capture, go to DONE.
- WRITE: drive mem_wr=1, mem_a = base+k and mem_dout = data[8k+7:8k] for k=0..N-1, one byte per cycle. Then go to DONE.
- DONE (one cycle):
  - pulse the owner's done output;
  - IF: _if_inst = assembled word;
  - loads: _lsb_result = value sign/zero-extended from bit 8N-1;
  - stores: _lsb_result = 0.
  - Next state is IDLE. Requesters deassert or replace their request at the edge ending DONE, and the arbiter never accepts in the DONE cycle.
- Address arithmetic wraps modulo 2^32.
- _clear:
  - in READ (IF or load): abort, go to IDLE next cycle with mem_wr=0 and no done pulse;
  - in IDLE: blocks acceptance in that cycle;
  - in WRITE or DONE for a store: ignored, and the store completes with its done pulse.
- rdy_in=0: all state, counters and registers hold. mem_wr is forced to 0 combinationally; the same byte is presented again when rdy_in returns. No done pulse is issued while frozen.
- Reset (rst_in=0 at an edge): state IDLE, counter 0, mem_a=0, mem_dout=0, mem_wr=0, _if_done=0, _lsb_done=0, _if_inst=0, _lsb_result=0. Reset overrides _clear and rdy_in. Reset mid-access abandons it without a done pulse.

## Timing
- Request first visible in cycle 0 (IDLE) → first address on mem_a in cycle 1.
- N-byte read: addresses cycles 1..N, data on mem_din cycles 2..N+1, done in cycle N+2. IF fetch done in cycle 6.
- N-byte write: mem_wr=1 in cycles 1..N, done in cycle N+1. Word store done in cycle 5.
- Back-to-back: the next acceptance is at the earliest in cycle done+1.
- Outputs mem_a/mem_dout/mem_wr are registered, apart from the rdy gating on mem_wr.
- done/result are registered and valid only in the done cycle.

## Test plan
- IF at 0x0000_1000, RAM bytes 13 05 00 00 → mem_a 0x1000..0x1003 in cycles 1–4, _if_done in cycle 6 with _if_inst=0x0000_0513.
- LSB and IF asserted together: load byte at 0x20, value 0x80, signed → LSB served first, _lsb_result=0xFFFF_FF80 in cycle 3. The IF then starts at cycle 4 and its _if_done arrives in cycle 10.
- Store half 0xBEEF to 0x100 → mem_wr=1 with (0x100,0xEF) in cycle 1 and (0x101,0xBE) in cycle 2, then _lsb_done in cycle 3.
- Store byte to 0x30000 with _io_buffer_full=1 and an IF pending → IF served and no write issued. After full drops, the store is accepted at the next IDLE.
- _clear in cycle 2 of a word load → no _lsb_done, IDLE in cycle 3. The same _clear during a word store → all 4 writes still occur and done arrives in cycle 5.
- rdy_in low for cycles 2–3 of a word store → mem_wr=0 in those cycles, no byte skipped or duplicated, done in cycle 7. rst_in low mid-read → all outputs return to zero next cycle.

Source files
------------

// File: rtl/memory_controller.sv
// rtl/memory_controller.sv - byte-serial arbiter/sequencer between instruction fetch and the load/store buffer
module memory_controller #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              _clear,
  input  logic              _if_ready,
  input  logic [ADDR_W-1:0] _if_addr,
  output logic              _if_done,
  output logic [31:0]       _if_inst,
  input  logic              _lsb_ready,
  input  logic              _lsb_is_store,
  input  logic [1:0]        _lsb_size,
  input  logic              _lsb_unsigned,
  input  logic [ADDR_W-1:0] _lsb_addr,
  input  logic [31:0]       _lsb_data,
  output logic              _lsb_done,
  output logic [31:0]       _lsb_result,
  input  logic              _io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e            state_q;
  logic              owner_lsb_q, uns_q;
  logic [ADDR_W-1:0] base_q, mem_a_q;
  logic [2:0]        len_q, cnt_q;
  logic [31:0]       data_q, if_inst_q, lsb_result_q;
  logic [7:0]        mem_dout_q;
  logic              mem_wr_q, if_done_q, lsb_done_q;

  logic              lsb_blocked, lsb_take;
  logic [2:0]        lsb_len, cnt_inc_d, cnt_dec_d;
  logic [ADDR_W-1:0] addr_inc_d;
  logic [7:0]        wbyte_d;
  logic [31:0]       asm_d, ext_d;
  logic              sign_d;

  // An IO store must wait while the IO write buffer is full; fetch may use the port meanwhile.
  assign lsb_blocked = _lsb_is_store && (_lsb_addr[17:16] == IO_HI) && _io_buffer_full;
  assign lsb_take    = _lsb_ready && !lsb_blocked;
  assign lsb_len     = (_lsb_size == 2'b00) ? 3'd1 : (_lsb_size == 2'b01) ? 3'd2 : 3'd4;
  assign cnt_inc_d   = cnt_q + 3'd1;
  assign cnt_dec_d   = cnt_q - 3'd1;
  assign addr_inc_d  = base_q + ADDR_W'(cnt_inc_d);
  assign wbyte_d     = data_q[{cnt_inc_d[1:0], 3'b000} +: 8];

  // mem_din holds the byte addressed one cycle earlier, i.e. byte cnt_q-1.
  always_comb begin
    asm_d = data_q;
    asm_d[{cnt_dec_d[1:0], 3'b000} +: 8] = mem_din;
    sign_d = 1'b0;
    ext_d  = asm_d;
    case (len_q)
      3'd1: begin
        sign_d = asm_d[7] & ~uns_q;
        ext_d  = {{24{sign_d}}, asm_d[7:0]};
      end
      3'd2: begin
        sign_d = asm_d[15] & ~uns_q;
        ext_d  = {{16{sign_d}}, asm_d[15:0]};
      end
      default: ext_d = asm_d;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      owner_lsb_q  <= 1'b0;
      uns_q        <= 1'b0;
      base_q       <= '0;
      len_q        <= 3'd0;
      cnt_q        <= 3'd0;
      data_q       <= 32'd0;
      mem_a_q      <= '0;
      mem_dout_q   <= 8'd0;
      mem_wr_q     <= 1'b0;
      if_done_q    <= 1'b0;
      lsb_done_q   <= 1'b0;
      if_inst_q    <= 32'd0;
      lsb_result_q <= 32'd0;
    end else if (rdy_in) begin
      case (state_q)
        IDLE: begin
          if (!_clear && lsb_take) begin
            owner_lsb_q <= 1'b1;
            uns_q       <= _lsb_unsigned;
            base_q      <= _lsb_addr;
            len_q       <= lsb_len;
            cnt_q       <= 3'd0;
            mem_a_q     <= _lsb_addr;
            if (_lsb_is_store) begin
              data_q     <= _lsb_data;
              mem_dout_q <= _lsb_data[7:0];
              mem_wr_q   <= 1'b1;
              state_q    <= WRITE;
            end else begin
              data_q  <= 32'd0;
              state_q <= READ;
            end
          end else if (!_clear && _if_ready) begin
            owner_lsb_q <= 1'b0;
            uns_q       <= 1'b1;
            base_q      <= _if_addr;
            len_q       <= 3'd4;
            cnt_q       <= 3'd0;
            data_q      <= 32'd0;
            mem_a_q     <= _if_addr;
            state_q     <= READ;
          end
        end
        READ: begin
          if (_clear) begin
            state_q <= IDLE;
          end else if (cnt_q == len_q) begin
            state_q <= DONE;
            if (owner_lsb_q) begin
              lsb_done_q   <= 1'b1;
              lsb_result_q <= ext_d;
            end else begin
              if_done_q <= 1'b1;
              if_inst_q <= asm_d;
            end
          end else begin
            if (cnt_q != 3'd0) data_q <= asm_d;
            if (cnt_inc_d < len_q) mem_a_q <= addr_inc_d;
            cnt_q <= cnt_inc_d;
          end
        end
        WRITE: begin
          // Committed stores run to completion; _clear is deliberately not looked at here.
          if (cnt_inc_d < len_q) begin
            cnt_q      <= cnt_inc_d;
            mem_a_q    <= addr_inc_d;
            mem_dout_q <= wbyte_d;
          end else begin
            mem_wr_q     <= 1'b0;
            state_q      <= DONE;
            lsb_done_q   <= 1'b1;
            lsb_result_q <= 32'd0;
          end
        end
        DONE: begin
          if_done_q  <= 1'b0;
          lsb_done_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_a       = mem_a_q;
  assign mem_dout    = mem_dout_q;
  assign mem_wr      = mem_wr_q & rdy_in;
  assign _if_done    = if_done_q & rdy_in;
  assign _lsb_done   = lsb_done_q & rdy_in;
  assign _if_inst    = if_inst_q;
  assign _lsb_result = lsb_result_q;
endmodule

// File: tb/tb_memory_controller.sv
// tb/tb_memory_controller.sv - randomized and directed bench for memory_controller against a slot-level model
module tb_memory_controller;
  localparam int RA = 0, RC = 1, WR = 2, DN = 3;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, _clear, _if_ready, _lsb_ready, _lsb_is_store, _lsb_unsigned, _io_buffer_full;
  logic [31:0] _if_addr, _lsb_addr, _lsb_data, _if_inst, _lsb_result, mem_a;
  logic [1:0]  _lsb_size;
  logic        _if_done, _lsb_done, mem_wr;
  logic [7:0]  mem_din, mem_dout;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 0, exp_zero = 0, ev_if_done = 0, ev_lsb_done = 0;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [7:0]  d;
    bit          lsb;
    logic [31:0] res;
  } slot_t;
  slot_t q[$];

  logic [7:0] ram   [logic [31:0]];
  logic [7:0] m_mem [logic [31:0]];

  logic [31:0] r_a[32], r_inst[32], r_res[32];
  logic [7:0]  r_d[32];
  logic        r_wr[32], r_ifd[32], r_lsd[32];

  always #5 clk_in = ~clk_in;

  memory_controller dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(_clear),
    ._if_ready(_if_ready), ._if_addr(_if_addr), ._if_done(_if_done), ._if_inst(_if_inst),
    ._lsb_ready(_lsb_ready), ._lsb_is_store(_lsb_is_store), ._lsb_size(_lsb_size),
    ._lsb_unsigned(_lsb_unsigned), ._lsb_addr(_lsb_addr), ._lsb_data(_lsb_data),
    ._lsb_done(_lsb_done), ._lsb_result(_lsb_result), ._io_buffer_full(_io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ {a[19:16], a[3:0]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] m_rd(input logic [31:0] a);
    if (m_mem.exists(a)) return m_mem[a];
    return init_byte(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a]   = b;
    m_mem[a] = b;
  endtask

  // RAM with one-cycle read latency; it stalls together with the rest of the system on rdy_in=0.
  always @(posedge clk_in) begin
    if (rdy_in) begin
      if (mem_wr) ram[mem_a] = mem_dout;
      mem_din <= ram_rd(mem_a);
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] a, input int n, input bit uns);
    logic [31:0] v;
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(m_rd(a + 32'(k))) << (8 * k));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic push(input int k, input logic [31:0] a, input logic [7:0] d, input bit lsb, input logic [31:0] res);
    slot_t s;
    s.kind = k; s.a = a; s.d = d; s.lsb = lsb; s.res = res;
    q.push_back(s);
  endtask

  // Each accepted request becomes a list of visible cycles: N address/write slots, a capture slot for reads, then done.
  task automatic model_accept();
    int n;
    bit lsb_ok;
    logic [31:0] v;
    lsb_ok = _lsb_ready && !(_lsb_is_store && _lsb_addr[17:16] == 2'b11 && _io_buffer_full);
    if (lsb_ok) begin
      n = (_lsb_size == 2'd0) ? 1 : (_lsb_size == 2'd1) ? 2 : 4;
      if (_lsb_is_store) begin
        for (int k = 0; k < n; k++) push(WR, _lsb_addr + 32'(k), 8'(_lsb_data >> (8 * k)), 1, 0);
        push(DN, 0, 0, 1, 0);
      end else begin
        v = load_value(_lsb_addr, n, _lsb_unsigned);
        for (int k = 0; k < n; k++) push(RA, _lsb_addr + 32'(k), 0, 1, 0);
        push(RC, 0, 0, 1, 0);
        push(DN, 0, 0, 1, v);
      end
    end else if (_if_ready) begin
      v = load_value(_if_addr, 4, 1);
      for (int k = 0; k < 4; k++) push(RA, _if_addr + 32'(k), 0, 0, 0);
      push(RC, 0, 0, 0, 0);
      push(DN, 0, 0, 0, v);
    end
  endtask

  always @(posedge clk_in) begin : model
    slot_t s;
    ev_if_done  = 0;
    ev_lsb_done = 0;
    if (!rst_in) begin
      q.delete();
      exp_zero = 1;
    end else begin
      exp_zero = 0;
      if (rdy_in) begin
        if (q.size() == 0) begin
          if (!_clear) model_accept();
        end else if (_clear && (q[0].kind == RA || q[0].kind == RC)) begin
          q.delete();
        end else begin
          s = q.pop_front();
          if (s.kind == WR) m_mem[s.a] = s.d;
          if (s.kind == DN) begin
            if (s.lsb) ev_lsb_done = 1;
            else ev_if_done = 1;
          end
        end
      end
    end
  end

  always @(negedge clk_in) begin
    if (checking) begin : cmp
      logic ewr, eifd, elsd;
      ewr = 0; eifd = 0; elsd = 0;
      if (exp_zero) begin
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_dout", mem_dout, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_if_done", _if_done, 0);
        chk("rst_lsb_done", _lsb_done, 0);
        chk("rst_if_inst", _if_inst, 0);
        chk("rst_lsb_result", _lsb_result, 0);
      end else begin
        if (q.size() != 0) begin
          case (q[0].kind)
            RA: chk("mem_a_rd", mem_a, q[0].a);
            WR: begin
              ewr = rdy_in;
              chk("mem_a_wr", mem_a, q[0].a);
              chk("mem_dout", mem_dout, q[0].d);
            end
            DN: if (rdy_in) begin
              if (q[0].lsb) begin
                elsd = 1;
                chk("lsb_result", _lsb_result, q[0].res);
              end else begin
                eifd = 1;
                chk("if_inst", _if_inst, q[0].res);
              end
            end
            default: ;
          endcase
        end
        chk("mem_wr", mem_wr, ewr);
        chk("if_done", _if_done, eifd);
        chk("lsb_done", _lsb_done, elsd);
      end
    end
  end

  // Records outputs for cycles 0..n-1 (cycle 0 = the cycle the request first appears) and drops a request after its done.
  task automatic watch(input int n, input int clr_c, input int rlo, input int rhi, input int rst_c);
    for (int c = 0; c < 32; c++) begin
      r_a[c] = 'x; r_d[c] = 'x; r_wr[c] = 0; r_ifd[c] = 0; r_lsd[c] = 0; r_inst[c] = 'x; r_res[c] = 'x;
    end
    for (int c = 0; c < n; c++) begin
      _clear = (c == clr_c);
      rdy_in = !(c >= rlo && c <= rhi);
      rst_in = (c != rst_c);
      @(negedge clk_in);
      r_a[c] = mem_a; r_d[c] = mem_dout; r_wr[c] = mem_wr;
      r_ifd[c] = _if_done; r_lsd[c] = _lsb_done; r_inst[c] = _if_inst; r_res[c] = _lsb_result;
      @(posedge clk_in); #1;
      if (r_ifd[c] === 1'b1) _if_ready = 0;
      if (r_lsd[c] === 1'b1) _lsb_ready = 0;
    end
    _clear = 0; rdy_in = 1; rst_in = 1;
  endtask

  function automatic int first_done(input bit lsb);
    for (int i = 0; i < 32; i++) if ((lsb ? r_lsd[i] : r_ifd[i]) === 1'b1) return i;
    return -1;
  endfunction

  function automatic int n_writes();
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) if (r_wr[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic settle();
    int t;
    t = 0;
    _if_ready = 0; _lsb_ready = 0; _clear = 0; rdy_in = 1; rst_in = 1; _io_buffer_full = 0;
    while (q.size() != 0 && t < 60) begin
      @(posedge clk_in); #1;
      t++;
    end
    chk("settle_timeout", (t < 60) ? 1 : 0, 1);
    @(posedge clk_in); #1;
  endtask

  task automatic set_lsb(input bit st, input logic [1:0] sz, input bit uns, input logic [31:0] a, input logic [31:0] d);
    _lsb_is_store = st; _lsb_size = sz; _lsb_unsigned = uns; _lsb_addr = a; _lsb_data = d; _lsb_ready = 1;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] b;
    case ($urandom_range(0, 3))
      0: b = 32'h0000_0100;
      1: b = 32'h0003_0000;
      2: b = 32'hFFFF_FFF8;
      default: b = 32'h0000_2000;
    endcase
    return b + 32'($urandom_range(0, 15));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 0; rdy_in = 1; _clear = 0; _if_ready = 0; _if_addr = 0; _lsb_ready = 0; _lsb_is_store = 0;
    _lsb_size = 0; _lsb_unsigned = 0; _lsb_addr = 0; _lsb_data = 0; _io_buffer_full = 0;
    @(posedge clk_in); #1;
    checking = 1;
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset_mem_wr", mem_wr, 0);
    chk("reset_mem_a", mem_a, 0);
    chk("reset_if_inst", _if_inst, 0);
    rst_in = 1;
    @(posedge clk_in); #1;

    // instruction fetch of 0x00000513
    preload(32'h1000, 8'h13); preload(32'h1001, 8'h05); preload(32'h1002, 8'h00); preload(32'h1003, 8'h00);
    _if_addr = 32'h1000; _if_ready = 1;
    watch(8, -1, -1, -1, -1);
    for (int i = 1; i <= 4; i++) chk("t1_addr", r_a[i], 32'h1000 + 32'(i - 1));
    chk("t1_done_cycle", first_done(0), 6);
    chk("t1_inst", r_inst[6], 32'h0000_0513);
    settle();

    // half store 0xBEEF to 0x100
    set_lsb(1, 2'b01, 0, 32'h100, 32'h0000_BEEF);
    watch(5, -1, -1, -1, -1);
    chk("t3_wr1", r_wr[1], 1); chk("t3_a1", r_a[1], 32'h100); chk("t3_d1", r_d[1], 8'hEF);
    chk("t3_wr2", r_wr[2], 1); chk("t3_a2", r_a[2], 32'h101); chk("t3_d2", r_d[2], 8'hBE);
    chk("t3_done_cycle", first_done(1), 3);
    settle();

    // IO store held off by a full buffer while a fetch proceeds
    _io_buffer_full = 1;
    set_lsb(1, 2'b00, 0, 32'h0003_0000, 32'h0000_005A);
    _if_addr = 32'h1000; _if_ready = 1;
    watch(9, -1, -1, -1, -1);
    chk("t4_if_done_cycle", first_done(0), 6);
    chk("t4_no_write", n_writes(), 0);
    chk("t4_no_lsb_done", first_done(1), -1);
    _io_buffer_full = 0;
    watch(4, -1, -1, -1, -1);
    chk("t4_wr", r_wr[1], 1); chk("t4_a", r_a[1], 32'h0003_0000); chk("t4_d", r_d[1], 8'h5A);
    chk("t4_done_cycle", first_done(1), 2);
    settle();

    // flush during a word load, then during a word store
    set_lsb(0, 2'b10, 0, 32'h200, 32'h0);
    watch(11, 2, -1, -1, -1);
    chk("t5_reaccept_addr", r_a[4], 32'h200);
    chk("t5_done_cycle", first_done(1), 9);
    settle();
    set_lsb(1, 2'b10, 0, 32'h140, 32'h1122_3344);
    watch(7, 2, -1, -1, -1);
    chk("t5s_writes", n_writes(), 4);
    chk("t5s_a4", r_a[4], 32'h143); chk("t5s_d4", r_d[4], 8'h11);
    chk("t5s_done_cycle", first_done(1), 5);
    settle();

    // freeze in cycles 2-3 of a word store
    set_lsb(1, 2'b11, 0, 32'h180, 32'hA1B2_C3D4);
    watch(9, -1, 2, 3, -1);
    chk("t6_wr2", r_wr[2], 0); chk("t6_wr3", r_wr[3], 0);
    chk("t6_writes", n_writes(), 4);
    chk("t6_a4", r_a[4], 32'h181); chk("t6_d4", r_d[4], 8'hC3);
    chk("t6_a6", r_a[6], 32'h183); chk("t6_d6", r_d[6], 8'hA1);
    chk("t6_done_cycle", first_done(1), 7);
    settle();

    // load beats fetch
    preload(32'h20, 8'h80);
    set_lsb(0, 2'b00, 0, 32'h20, 32'h0);
    _if_addr = 32'h1000; _if_ready = 1;
    watch(12, -1, -1, -1, -1);
    chk("t2_lsb_done_cycle", first_done(1), 3);
    chk("t2_lsb_result", r_res[3], 32'hFFFF_FF80);
    chk("t2_if_addr5", r_a[5], 32'h1000);
    chk("t2_if_done_cycle", first_done(0), 10);
    chk("t2_if_inst", r_inst[10], 32'h0000_0513);
    settle();

    // reset in the middle of a fetch
    _if_addr = 32'h1000; _if_ready = 1;
    watch(5, -1, -1, -1, 2);
    chk("t7_a2", r_a[2], 32'h1001);
    chk("t7_a3", r_a[3], 0); chk("t7_d3", r_d[3], 0); chk("t7_wr3", r_wr[3], 0);
    chk("t7_inst3", r_inst[3], 0); chk("t7_res3", r_res[3], 0);
    chk("t7_ifd3", r_ifd[3], 0); chk("t7_lsd3", r_lsd[3], 0);
    settle();

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk_in); #1;
      rst_in = ($urandom_range(0, 299) != 0);
      rdy_in = ($urandom_range(0, 99) < 85);
      _clear = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 9) == 0) _io_buffer_full = ~_io_buffer_full;
      if (ev_if_done || !_if_ready) begin
        _if_ready = ($urandom_range(0, 2) != 0);
        _if_addr  = rnd_addr();
      end
      if (ev_lsb_done || !_lsb_ready) begin
        _lsb_ready     = ($urandom_range(0, 2) != 0);
        _lsb_is_store  = $urandom_range(0, 1) == 1;
        _lsb_size      = 2'($urandom_range(0, 3));
        _lsb_unsigned  = $urandom_range(0, 1) == 1;
        _lsb_addr      = rnd_addr();
        _lsb_data      = $urandom;
      end
    end
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
